// File: rtl/wb_commit_queue_pkg.sv
// Shared widths and entry type for the write-back commit queue.
// Project-wide widths may be predefined by the build; these are fallbacks.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_FILE_ADDRESS_LEN
`define REG_FILE_ADDRESS_LEN 5
`endif
`ifndef WB_QUEUE_DEPTH
`define WB_QUEUE_DEPTH 4
`endif

package wb_commit_queue_pkg;
  localparam int WORD_W      = `WORD_WIDTH;
  localparam int ADDR_W      = `REG_FILE_ADDRESS_LEN;
  localparam int QUEUE_DEPTH = `WB_QUEUE_DEPTH;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [WORD_W-1:0] value;
  } wb_entry_t;
endpackage

// File: rtl/wb_commit_queue_fwd_lookup.sv
// Youngest-first match of one read address over N {valid,dest,value} slots.
// Slot 0 is the youngest; a lower index wins over a higher one.
module wb_fwd_lookup
  import wb_commit_queue_pkg::*;
#(
  parameter int N  = QUEUE_DEPTH + 1,
  parameter int AW = ADDR_W,
  parameter int DW = WORD_W
) (
  input  logic [N-1:0]         i_valid,
  input  logic [N-1:0][AW-1:0] i_dest,
  input  logic [N-1:0][DW-1:0] i_val,
  input  logic [AW-1:0]        i_src,
  output logic                 o_hit,
  output logic [DW-1:0]        o_val
);

  always_comb begin
    o_hit = 1'b0;
    o_val = '0;
    // Scan oldest to youngest so the youngest match overwrites the rest.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_valid[i] && (i_dest[i] == i_src)) begin
        o_hit = 1'b1;
        o_val = i_val[i];
      end
    end
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Write-back commit queue: buffers MEM results, drains one per cycle to the
// register-file write port and forwards in-flight values to ID.
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [WORD_W-1:0] in_result,
  input  logic              wb_hold,
  output logic              writeBackEn,
  output logic [ADDR_W-1:0] dest_wb,
  output logic [WORD_W-1:0] result_WB,
  input  logic [ADDR_W-1:0] fwd_src1,
  input  logic [ADDR_W-1:0] fwd_src2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [WORD_W-1:0] fwd_val1,
  output logic [WORD_W-1:0] fwd_val2,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_wb_en;
  logic [ADDR_W-1:0]  r_dest_wb;
  logic [WORD_W-1:0]  r_result_wb;

  logic w_full;
  logic w_push;
  logic w_pop;

  // in_ready depends only on state and reset, never on wb_hold.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign in_ready = rst & ~w_full;
  assign w_push   = in_valid & in_ready & in_wb_en;
  assign w_pop    = (r_count != '0) & ~wb_hold;

  assign writeBackEn = r_wb_en;
  assign dest_wb     = r_dest_wb;
  assign result_WB   = r_result_wb;
  assign empty       = (r_count == '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{dest: in_dest, value: in_result};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_wb_en     <= 1'b0;
      r_dest_wb   <= '0;
      r_result_wb <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_dest_wb   <= r_mem[r_rd_ptr].dest;
        r_result_wb <= r_mem[r_rd_ptr].value;
      end
      r_wb_en <= w_pop;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Forwarding slots ordered youngest first; the last slot is the output register.
  logic [DEPTH:0]             w_slot_valid;
  logic [DEPTH:0][ADDR_W-1:0] w_slot_dest;
  logic [DEPTH:0][WORD_W-1:0] w_slot_val;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PTR_W-1:0] w_idx;
    assign w_idx           = r_wr_ptr - PTR_W'(g + 1);
    assign w_slot_valid[g] = (CNT_W'(g) < r_count);
    assign w_slot_dest[g]  = r_mem[w_idx].dest;
    assign w_slot_val[g]   = r_mem[w_idx].value;
  end

  assign w_slot_valid[DEPTH] = r_wb_en;
  assign w_slot_dest[DEPTH]  = r_dest_wb;
  assign w_slot_val[DEPTH]   = r_result_wb;

  wb_fwd_lookup #(.N(DEPTH + 1), .AW(ADDR_W), .DW(WORD_W)) u_fwd1 (
    .i_valid (w_slot_valid),
    .i_dest  (w_slot_dest),
    .i_val   (w_slot_val),
    .i_src   (fwd_src1),
    .o_hit   (fwd_hit1),
    .o_val   (fwd_val1)
  );

  wb_fwd_lookup #(.N(DEPTH + 1), .AW(ADDR_W), .DW(WORD_W)) u_fwd2 (
    .i_valid (w_slot_valid),
    .i_dest  (w_slot_dest),
    .i_val   (w_slot_val),
    .i_src   (fwd_src2),
    .o_hit   (fwd_hit2),
    .o_val   (fwd_val2)
  );

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue: reset, single write, full, streaming,
// forwarding priority, non-writing instructions and mid-stream reset.
module tb_wb_commit_queue;
  import wb_commit_queue_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_wb_en;
  logic [ADDR_W-1:0] in_dest;
  logic [WORD_W-1:0] in_result;
  logic              wb_hold;
  logic              writeBackEn;
  logic [ADDR_W-1:0] dest_wb;
  logic [WORD_W-1:0] result_WB;
  logic [ADDR_W-1:0] fwd_src1;
  logic [ADDR_W-1:0] fwd_src2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [WORD_W-1:0] fwd_val1;
  logic [WORD_W-1:0] fwd_val2;
  logic              empty;

  int total = 0;
  int bad   = 0;

  wb_commit_queue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wb_en    (in_wb_en),
    .in_dest     (in_dest),
    .in_result   (in_result),
    .wb_hold     (wb_hold),
    .writeBackEn (writeBackEn),
    .dest_wb     (dest_wb),
    .result_WB   (result_WB),
    .fwd_src1    (fwd_src1),
    .fwd_src2    (fwd_src2),
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_val1    (fwd_val1),
    .fwd_val2    (fwd_val2),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic en, input int d, input int r);
    in_valid  = v;
    in_wb_en  = en;
    in_dest   = ADDR_W'(d);
    in_result = WORD_W'(r);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    wb_hold = 1'b0;
    fwd_src1 = '0;
    fwd_src2 = '0;
    drive(1'b0, 1'b0, 0, 0);
    #2;
    chk("rst_wben", writeBackEn, 0);
    chk("rst_dest", dest_wb, 0);
    chk("rst_result", result_WB, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", in_ready, 0);
    chk("rst_hit1", fwd_hit1, 0);
    chk("rst_hit2", fwd_hit2, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // Single write.
    drive(1'b1, 1'b1, 5, 32'hA5A5);
    tick();
    drive(1'b0, 1'b1, 0, 0);
    fwd_src1 = 5;
    #1;
    chk("sw_k_wben", writeBackEn, 0);
    chk("sw_k_empty", empty, 0);
    chk("sw_k_hit1", fwd_hit1, 1);
    chk("sw_k_val1", fwd_val1, 32'hA5A5);
    tick();
    chk("sw_k1_wben", writeBackEn, 1);
    chk("sw_k1_dest", dest_wb, 5);
    chk("sw_k1_result", result_WB, 32'hA5A5);
    chk("sw_k1_empty", empty, 1);
    chk("sw_k1_hit1_outreg", fwd_hit1, 1);
    chk("sw_k1_val1_outreg", fwd_val1, 32'hA5A5);
    tick();
    chk("sw_k2_wben", writeBackEn, 0);
    chk("sw_k2_dest_hold", dest_wb, 5);
    chk("sw_k2_hit1", fwd_hit1, 0);
    chk("sw_k2_val1", fwd_val1, 0);

    // Fill to full under hold, then drain.
    wb_hold = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      drive(1'b1, 1'b1, d, 100 + d);
      #1;
      chk("fill_ready", in_ready, 1);
      tick();
    end
    drive(1'b1, 1'b1, 9, 999);
    chk("full_ready", in_ready, 0);
    tick();
    drive(1'b0, 1'b1, 0, 0);
    chk("full_wben", writeBackEn, 0);
    chk("full_ready2", in_ready, 0);
    fwd_src1 = 3;
    fwd_src2 = 9;
    #1;
    chk("full_hit1", fwd_hit1, 1);
    chk("full_val1", fwd_val1, 103);
    chk("full_hit2_rejected", fwd_hit2, 0);
    chk("full_val2_rejected", fwd_val2, 0);
    wb_hold = 1'b0;
    #1;
    chk("full_ready_no_hold_path", in_ready, 0);
    for (int d = 1; d <= 4; d++) begin
      tick();
      chk("drain_wben", writeBackEn, 1);
      chk("drain_dest", dest_wb, d);
      chk("drain_result", result_WB, 100 + d);
      chk("drain_ready", in_ready, 1);
    end
    tick();
    chk("drain_end_wben", writeBackEn, 0);
    chk("drain_end_empty", empty, 1);

    // Steady-state push and pop every cycle.
    for (int i = 0; i < 6; i++) begin
      drive(i < 5, 1'b1, 10 + i, 200 + i);
      tick();
      chk("ss_wben", writeBackEn, (i >= 1) ? 1 : 0);
      if (i >= 1) begin
        chk("ss_dest", dest_wb, 10 + i - 1);
        chk("ss_result", result_WB, 200 + i - 1);
      end
      chk("ss_empty", empty, (i == 5) ? 1 : 0);
      chk("ss_ready", in_ready, 1);
    end
    drive(1'b0, 1'b1, 0, 0);
    tick();
    chk("ss_end_wben", writeBackEn, 0);

    // Forwarding priority: two writes to r7.
    wb_hold = 1'b1;
    drive(1'b1, 1'b1, 7, 1);
    tick();
    drive(1'b1, 1'b1, 7, 2);
    tick();
    drive(1'b0, 1'b1, 0, 0);
    fwd_src1 = 7;
    fwd_src2 = 9;
    #1;
    chk("fwd_hit1", fwd_hit1, 1);
    chk("fwd_val1_youngest", fwd_val1, 2);
    chk("fwd_hit2_none", fwd_hit2, 0);
    chk("fwd_val2_none", fwd_val2, 0);
    wb_hold = 1'b0;
    tick();
    chk("fwd_pop1_result", result_WB, 1);
    chk("fwd_q_over_outreg_hit", fwd_hit1, 1);
    chk("fwd_q_over_outreg_val", fwd_val1, 2);
    tick();
    chk("fwd_pop2_result", result_WB, 2);
    chk("fwd_outreg_val", fwd_val1, 2);
    tick();
    chk("fwd_done_hit1", fwd_hit1, 0);
    chk("fwd_done_val1", fwd_val1, 0);

    // Non-writing instruction is consumed silently.
    drive(1'b1, 1'b0, 3, 55);
    #1;
    chk("nw_ready_before", in_ready, 1);
    tick();
    drive(1'b0, 1'b1, 0, 0);
    chk("nw_ready_after", in_ready, 1);
    chk("nw_empty", empty, 1);
    chk("nw_wben", writeBackEn, 0);
    tick();
    chk("nw_wben2", writeBackEn, 0);

    // Reset mid-stream with three entries queued.
    wb_hold = 1'b1;
    for (int d = 20; d <= 22; d++) begin
      drive(1'b1, 1'b1, d, 300 + d);
      tick();
    end
    drive(1'b0, 1'b1, 0, 0);
    chk("mr_empty_before", empty, 0);
    rst = 1'b0;
    fwd_src1 = 20;
    #1;
    chk("mr_wben", writeBackEn, 0);
    chk("mr_dest", dest_wb, 0);
    chk("mr_result", result_WB, 0);
    chk("mr_empty", empty, 1);
    chk("mr_ready", in_ready, 0);
    chk("mr_hit1", fwd_hit1, 0);
    tick();
    rst = 1'b1;
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_after_wben", writeBackEn, 0);
      chk("mr_after_empty", empty, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
